// File: rtl/spi_rx_trig_if.sv
// SPI bus bundle as seen by the passive monitor.
// The master modport drives the bus; the slave modport only observes it.
interface spi_rx_trig_if;
    logic SS_n;
    logic SCLK;
    logic MOSI;

    modport master (output SS_n, output SCLK, output MOSI);
    modport slave  (input  SS_n, input  SCLK, input  MOSI);
endinterface

// File: rtl/spi_rx_trig.sv
// Passive SPI monitor: it synchronises the bus and assembles frames of programmable length.
// At frame end it reports the word and the per-channel mask/match hits, and raises a trigger pulse.
module spi_rx_trig #(
    parameter  int MAX_BITS = 16,
    parameter  int NUM_CH   = 2,
    localparam int LW       = $clog2(MAX_BITS + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    spi_rx_trig_if.slave               spi,
    input  logic                       edg,
    input  logic                       lsb_first,
    input  logic [LW-1:0]              len,
    input  logic [NUM_CH*MAX_BITS-1:0] mask,
    input  logic [NUM_CH*MAX_BITS-1:0] match,
    output logic [MAX_BITS-1:0]        rx_data,
    output logic                       rx_vld,
    output logic [NUM_CH-1:0]          ch_hit,
    output logic                       SPItrig,
    output logic                       frm_err
);

    localparam logic [LW-1:0] MAX_L = LW'(MAX_BITS);

    typedef enum logic {IDLE, RX} state_t;

    // Stage 0 and 1 resolve metastability; stage 2 is the history used for edge detection.
    logic [2:0] ss_q, sclk_q, mosi_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_q   <= 3'b111;
            sclk_q <= 3'b000;
            mosi_q <= 3'b000;
        end else begin
            ss_q   <= {ss_q[1:0], spi.SS_n};
            sclk_q <= {sclk_q[1:0], spi.SCLK};
            mosi_q <= {mosi_q[1:0], spi.MOSI};
        end
    end

    logic ss_low, ss_rise, sclk_rise, sclk_fall, bit_edge, mosi_bit;

    assign ss_low    = ~ss_q[1];
    assign ss_rise   = ss_q[1] & ~ss_q[2];
    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign bit_edge  = edg ? sclk_rise : sclk_fall;
    assign mosi_bit  = mosi_q[2];

    logic [LW-1:0] len_eff;
    assign len_eff = ((len == '0) || (len > MAX_L)) ? MAX_L : len;

    state_t             state_q, state_d;
    logic [MAX_BITS-1:0] word_q, word_d;
    logic [LW-1:0]       cnt_q, cnt_d;
    logic [LW-1:0]       len_q, len_d;
    logic                ovr_q, ovr_d;
    logic                done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            word_q  <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        ovr_d   = ovr_q;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (ss_low) begin
                    state_d = RX;
                    word_d  = '0;
                    cnt_d   = '0;
                    len_d   = len_eff;
                    ovr_d   = 1'b0;
                end
            end
            RX: begin
                // A clock edge arriving together with the SS_n rise is deliberately dropped.
                if (ss_rise) begin
                    state_d = IDLE;
                    done    = 1'b1;
                end else if (bit_edge) begin
                    if (cnt_q < len_q) begin
                        cnt_d = cnt_q + LW'(1);
                        if (lsb_first) begin
                            for (int i = 0; i < MAX_BITS; i++) begin
                                if (cnt_q == LW'(i)) begin
                                    word_d[i] = mosi_bit;
                                end
                            end
                        end else begin
                            word_d = {word_q[MAX_BITS-2:0], mosi_bit};
                        end
                    end else begin
                        ovr_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Only the bits of the current frame take part in the comparison.
    logic [MAX_BITS-1:0] lenmask;
    logic [NUM_CH-1:0]   hit_d;
    logic                err_d;

    for (genvar gi = 0; gi < MAX_BITS; gi++) begin : g_lenmask
        assign lenmask[gi] = (LW'(gi) < len_q);
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign hit_d[gi] = ~|((word_q ^ match[gi*MAX_BITS +: MAX_BITS])
                              & ~mask[gi*MAX_BITS +: MAX_BITS] & lenmask);
    end

    assign err_d = (cnt_q != len_q) | ovr_q;

    logic [MAX_BITS-1:0] rx_data_q;
    logic [NUM_CH-1:0]   ch_hit_q;
    logic                rx_vld_q, trig_q, frm_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data_q <= '0;
            ch_hit_q  <= '0;
            rx_vld_q  <= 1'b0;
            trig_q    <= 1'b0;
            frm_err_q <= 1'b0;
        end else begin
            rx_vld_q  <= done;
            frm_err_q <= done & err_d;
            trig_q    <= done & ~err_d & (|hit_d);
            if (done) begin
                rx_data_q <= word_q;
                ch_hit_q  <= hit_d;
            end
        end
    end

    assign rx_data = rx_data_q;
    assign ch_hit  = ch_hit_q;
    assign rx_vld  = rx_vld_q;
    assign SPItrig = trig_q;
    assign frm_err = frm_err_q;

endmodule

// File: tb/tb_spi_rx_trig.sv
// Directed bench for spi_rx_trig: a table of frames with hand-computed reports,
// plus sequences for reset mid-frame and an SCLK edge coincident with the SS_n rise.
module tb_spi_rx_trig;

    localparam int MB = 16;
    localparam int NC = 2;
    localparam int LW = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            edg = 1'b1;
    logic            lsb_first = 1'b0;
    logic [LW-1:0]   len = 5'd8;
    logic [NC*MB-1:0] mask = '0;
    logic [NC*MB-1:0] match = '0;
    logic [MB-1:0]   rx_data;
    logic            rx_vld;
    logic [NC-1:0]   ch_hit;
    logic            SPItrig;
    logic            frm_err;

    spi_rx_trig_if bus ();

    spi_rx_trig #(.MAX_BITS(MB), .NUM_CH(NC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi       (bus),
        .edg       (edg),
        .lsb_first (lsb_first),
        .len       (len),
        .mask      (mask),
        .match     (match),
        .rx_data   (rx_data),
        .rx_vld    (rx_vld),
        .ch_hit    (ch_hit),
        .SPItrig   (SPItrig),
        .frm_err   (frm_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int vld_cnt = 0;

    always @(posedge clk) begin
        if (rx_vld) vld_cnt <= vld_cnt + 1;
    end

    typedef struct {
        logic [31:0]   tx;
        int            nbits;
        logic [LW-1:0] len;
        logic          edg;
        logic          lsb;
        logic [31:0]   mask;
        logic [31:0]   match;
        logic [15:0]   exp_data;
        logic [1:0]    exp_hit;
        logic          exp_err;
        logic          exp_trig;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [31:0] tx, input int n, input logic lsb);
        for (int i = 0; i < n; i++) begin
            int idx;
            idx = lsb ? i : (n - 1 - i);
            bus.MOSI = tx[idx];
            tick(4);
            bus.SCLK = 1'b1;
            tick(4);
            bus.SCLK = 1'b0;
        end
    endtask

    // Wait (bounded) for the report pulse, then check it and that it lasts one cycle.
    task automatic check_report(input string tag, input logic [15:0] e_data, input logic [1:0] e_hit,
                                input logic e_err, input logic e_trig);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            tick(1);
            if (rx_vld) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s.rx_vld: got no pulse expected pulse within 30 cycles", tag);
        end else begin
            $display("frame %s: data=0x%04h hit=%b err=%b trig=%b", tag, rx_data, ch_hit, frm_err, SPItrig);
            check({tag, ".data"}, 32'(rx_data), 32'(e_data));
            check({tag, ".hit"},  32'(ch_hit),  32'(e_hit));
            check({tag, ".err"},  32'(frm_err), 32'(e_err));
            check({tag, ".trig"}, 32'(SPItrig), 32'(e_trig));
            tick(1);
            check({tag, ".pulses_after"}, {29'd0, rx_vld, frm_err, SPItrig}, 32'd0);
            check({tag, ".data_hold"}, {14'd0, ch_hit, rx_data}, {14'd0, e_hit, e_data});
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        len       = v.len;
        edg       = v.edg;
        lsb_first = v.lsb;
        mask      = v.mask;
        match     = v.match;
        bus.SCLK  = 1'b0;
        tick(2);
        bus.SS_n = 1'b0;
        tick(6);
        send_bits(v.tx, v.nbits, v.lsb);
        tick(4);
        bus.SS_n = 1'b1;
        check_report(tag, v.exp_data, v.exp_hit, v.exp_err, v.exp_trig);
        tick(4);
    endtask

    initial begin
        int vld0;
        // tx, nbits, len, edg, lsb, mask{ch1,ch0}, match{ch1,ch0}, data, hit, err, trig
        vecs[0] = '{32'h00A5, 8,  5'd8,  1'b1, 1'b0, 32'h0000_0000, 32'h00FF_00A5, 16'h00A5, 2'b01, 1'b0, 1'b1};
        vecs[1] = '{32'h1234, 16, 5'd0,  1'b0, 1'b1, 32'h00FF_FF00, 32'h1300_0034, 16'h1234, 2'b01, 1'b0, 1'b1};
        vecs[2] = '{32'h0297, 10, 5'd8,  1'b1, 1'b0, 32'h0000_0000, 32'h00FF_00A5, 16'h00A5, 2'b01, 1'b1, 1'b0};
        vecs[3] = '{32'h0016, 5,  5'd8,  1'b1, 1'b0, 32'h0000_0000, 32'h00FF_0016, 16'h0016, 2'b01, 1'b1, 1'b0};
        vecs[4] = '{32'h0000, 0,  5'd8,  1'b1, 1'b0, 32'h0000_0000, 32'h00FF_0000, 16'h0000, 2'b01, 1'b1, 1'b0};
        vecs[5] = '{32'h003C, 8,  5'd8,  1'b1, 1'b1, 32'h0000_000F, 32'h003C_0030, 16'h003C, 2'b11, 1'b0, 1'b1};
        vecs[6] = '{32'hBEEF, 16, 5'd20, 1'b0, 1'b0, 32'h0000_0000, 32'hBEEE_BEEF, 16'hBEEF, 2'b01, 1'b0, 1'b1};
        vecs[7] = '{32'h000A, 4,  5'd4,  1'b1, 1'b1, 32'h000F_0000, 32'h0005_FFFA, 16'h000A, 2'b11, 1'b0, 1'b1};
        vecs[8] = '{32'h005A, 8,  5'd8,  1'b1, 1'b0, 32'h0000_0000, 32'h00A5_00A5, 16'h005A, 2'b00, 1'b0, 1'b0};

        bus.SS_n = 1'b1;
        bus.SCLK = 1'b0;
        bus.MOSI = 1'b0;
        tick(3);
        check("reset.outputs", {10'd0, rx_vld, SPItrig, frm_err, ch_hit, rx_data}, 32'd0);
        rst_n = 1'b1;
        tick(3);

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end

        // Reset after 4 of 8 bits: frame dropped, outputs cleared, next frame decodes.
        len = 5'd8; edg = 1'b1; lsb_first = 1'b0;
        mask = 32'h0; match = 32'h00FF_00A5;
        bus.SS_n = 1'b0;
        tick(6);
        send_bits(32'hA, 4, 1'b0);
        tick(2);
        rst_n = 1'b0;
        tick(3);
        bus.SS_n = 1'b1;
        tick(2);
        rst_n = 1'b1;
        vld0 = vld_cnt;
        tick(20);
        $display("reset mid-frame: vld_pulses=%0d data=0x%04h hit=%b", vld_cnt - vld0, rx_data, ch_hit);
        check("rst.no_vld", 32'(vld_cnt - vld0), 32'd0);
        check("rst.outputs", {10'd0, rx_vld, SPItrig, frm_err, ch_hit, rx_data}, 32'd0);
        run_vec(vecs[0], "after_rst");

        // Ninth SCLK rise arrives together with SS_n rising: it must be ignored.
        len = 5'd8; edg = 1'b1; lsb_first = 1'b0;
        mask = 32'h0; match = 32'h00FF_00A5;
        bus.SS_n = 1'b0;
        tick(6);
        send_bits(32'hA5, 8, 1'b0);
        bus.MOSI = 1'b1;
        tick(4);
        bus.SCLK = 1'b1;
        bus.SS_n = 1'b1;
        check_report("coincident", 16'h00A5, 2'b01, 1'b0, 1'b1);
        bus.SCLK = 1'b0;
        tick(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_rx_trig.md
Name: spi_rx_trig

Overview:
Parametrised SPI-monitor receiver with trigger generation. It passively samples an SPI bus (SS_n, SCLK, MOSI) with frame lengths programmable up to MAX_BITS and selectable bit order. At end of frame it compares the received word against NUM_CH independent mask/match channels. It emits a one-cycle trigger and frame report to the capture/trigger logic of the logic-analyzer front end.

Parameters:
MAX_BITS, 16, maximum frame length in bits and width of the data path (>=2).
NUM_CH, 2, number of independent mask/match comparison channels (>=1).
LW, $clog2(MAX_BITS+1), width of len and of the internal bit counter (derived; not overridden).

Ports:
clk  input  1  system clock.
rst_n  input  1  asynchronous active-low reset.
SS_n  input  1  SPI slave select, asynchronous, active low.
SCLK  input  1  SPI clock, asynchronous.
MOSI  input  1  SPI data, asynchronous.
edg  input  1  1 = sample MOSI on SCLK rise; 0 = sample on SCLK fall.
lsb_first  input  1  1 = first bit received is bit 0; 0 = first bit is bit len-1.
len  input  LW  expected frame length in bits; 0 means MAX_BITS; values >MAX_BITS are treated as MAX_BITS.
mask  input  NUM_CH*MAX_BITS  per-channel don't-care bits (1 = ignore); channel k uses slice [k*MAX_BITS +: MAX_BITS].
match  input  NUM_CH*MAX_BITS  per-channel compare value, same slicing as mask.
rx_data  output  MAX_BITS  last completed frame, right-aligned, bits >= len are 0.
rx_vld  output  1  one-cycle pulse: a frame ended; rx_data, ch_hit and frm_err are valid.
ch_hit  output  NUM_CH  per-channel match result of last frame; held until the next frame end.
SPItrig  output  1  one-cycle pulse = rx_vld & ~frm_err & |ch_hit.
frm_err  output  1  one-cycle pulse with rx_vld when bit count != effective len.

Behaviour:
- Reset: rst_n is asynchronous and active low; clock is clk. All outputs reset to 0. Shift register and bit counter reset to 0. State resets to IDLE.
- Synchronisers: SS_n, SCLK and MOSI each pass through 3 flops (2 metastability, 1 history). SS_n flops reset to 1; SCLK and MOSI flops reset to 0. Edge detect compares stage 2 with stage 3. Edges are acted on with their stage-3 MOSI.
- Effective length L = (len==0 || len>MAX_BITS) ? MAX_BITS : len. L is sampled when the frame starts (IDLE->RX) and held for the whole frame.
- FSM states:
  - IDLE: on sync SS_n==0, go to RX, clear shift register and bit counter, latch L.
  - RX: on a selected SCLK edge with bit count < L, store the bit and increment the count. When bit count == L, further edges only set the sticky overrun flag; the count saturates at L. On sync SS_n==1, go to IDLE and assert done for one cycle. If SS_n rises in the same cycle as an edge, the edge is discarded.
- Bit storage:
  - MSB-first: shift left, inserting at bit 0.
  - LSB-first: write bit at index [count].
  - Both produce a right-aligned word; bits >= L stay 0.
- On done, register the following (visible the cycle after done, so latency is 1 clk after sync SS_n rise):
  - rx_data = word.
  - ch_hit[k] = (((word ^ match_k) & ~mask_k & lenmask) == 0), where lenmask has ones in bits [L-1:0].
  - frm_err = (count != L) | overrun.
  - rx_vld = 1.
  - SPItrig per its port definition.
- Pulse timing: rx_vld, SPItrig and frm_err pulse for exactly one cycle. rx_data and ch_hit hold until the next frame end.
- Zero-bit frame (SS_n low then high, no edges): rx_vld=1, frm_err=1, SPItrig=0.
- Reset mid-frame: the frame is dropped with no rx_vld. After reset, if SS_n is already low, a new frame starts (the SS_n sync resets high, so a fall is observed).
- mask/match/edg/lsb_first may change at any time. edg and lsb_first must be stable during a frame. mask/match are sampled on the done cycle.

Test Plan:
- MAX_BITS=16, NUM_CH=2, len=8, edg=1, MSB-first, send 0xA5. ch0 match=0x00A5 mask=0, ch1 match=0x00FF mask=0 -> rx_data=0x00A5, ch_hit=2'b01, SPItrig=1, frm_err=0, all pulses exactly 1 clk.
- len=0 (=16), edg=0, LSB-first, send first-bit-first sequence for 0x1234. ch0 mask=0xFF00, match=0x0034 -> rx_data=0x1234, ch_hit[0]=1, SPItrig=1.
- len=8, send 10 bits -> frm_err=1, rx_data holds first 8 bits, SPItrig=0 even if ch_hit=1. Send 5 bits -> frm_err=1, SPItrig=0.
- SS_n toggled low/high with no SCLK -> rx_vld=1, frm_err=1, rx_data=0, SPItrig=0.
- Assert rst_n low after 4 of 8 bits, release with SS_n high -> no rx_vld, outputs 0. The next full 8-bit frame decodes correctly.
- SCLK edge coincident with SS_n rise on bit 9 of an 8-bit frame -> edge discarded, frm_err=0, SPItrig per match.
